// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS core: opcodes, functs, FSM states, ALU ops.
// Also holds the instruction legality check and the ALU-op decode.
package mips_mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6
    } alu_op_t;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_SLL, FN_SRL, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: return 1'b1;
                    default: return 1'b0;
                endcase
            end
            OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Everything that is not R-type only needs an adder (addi, address calc).
    function automatic alu_op_t alu_decode(input logic [5:0] op, input logic [5:0] fn);
        if (op != OP_RTYPE) return ALU_ADD;
        case (fn)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            FN_SLL:  return ALU_SLL;
            FN_SRL:  return ALU_SRL;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port.
// R[0] is never written and always reads as zero.
module mips_mc_regfile (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_raddr_a,
    input  logic [4:0]  i_raddr_b,
    output logic [31:0] o_rdata_a,
    output logic [31:0] o_rdata_b
);
    logic [31:0] r_regs [32];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (i_we && (i_waddr != 5'd0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = (i_raddr_a == 5'd0) ? 32'd0 : r_regs[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == 5'd0) ? 32'd0 : r_regs[i_raddr_b];

endmodule

// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS core: FETCH/DECODE/EXEC/MEM/WB sequencer over one shared ALU
// and a single unified memory port with a ready handshake; traps on illegal ops.
import mips_mc_pkg::*;

module mips_multicycle #(
    parameter logic [31:0] RESET_PC         = 32'h0000_0000,
    parameter bit          TRAP_ON_MISALIGN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ready,
    output logic [31:0] o_pcout,
    output logic [31:0] o_instruction,
    output logic [2:0]  o_state,
    output logic        o_halted,
    output logic [31:0] o_instret
);
    state_t      r_state, w_state_next;
    logic [31:0] r_pc, r_npc, r_ir, r_a, r_b, r_tgt, r_alu_out, r_mdr, r_instret;

    logic [5:0]  w_op, w_fn;
    logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
    logic [31:0] w_sext, w_rs_data, w_rt_data, w_alu_b, w_alu_res, w_pc_next;
    logic        w_is_r, w_is_mem, w_is_br, w_taken, w_misalign, w_retire, w_pc_we;
    logic        w_rf_we, w_req, w_we;
    logic [4:0]  w_rf_waddr;
    logic [31:0] w_rf_wdata, w_addr, w_wdata;

    assign w_op     = r_ir[31:26];
    assign w_rs     = r_ir[25:21];
    assign w_rt     = r_ir[20:16];
    assign w_rd     = r_ir[15:11];
    assign w_shamt  = r_ir[10:6];
    assign w_fn     = r_ir[5:0];
    assign w_sext   = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_is_r   = (w_op == OP_RTYPE);
    assign w_is_mem = (w_op == OP_LW) || (w_op == OP_SW);
    assign w_is_br  = (w_op == OP_BEQ) || (w_op == OP_BNE);
    assign w_taken  = (r_a == r_b) ^ (w_op == OP_BNE);

    mips_mc_regfile u_regfile (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_we      (w_rf_we),
        .i_waddr   (w_rf_waddr),
        .i_wdata   (w_rf_wdata),
        .i_raddr_a (w_rs),
        .i_raddr_b (w_rt),
        .o_rdata_a (w_rs_data),
        .o_rdata_b (w_rt_data)
    );

    assign w_alu_b = w_is_r ? r_b : w_sext;

    always_comb begin
        w_alu_res = r_a + w_alu_b;
        case (alu_decode(w_op, w_fn))
            ALU_SUB: w_alu_res = r_a - w_alu_b;
            ALU_AND: w_alu_res = r_a & w_alu_b;
            ALU_OR:  w_alu_res = r_a | w_alu_b;
            ALU_SLT: w_alu_res = {31'd0, $signed(r_a) < $signed(w_alu_b)};
            ALU_SLL: w_alu_res = r_b << w_shamt;
            ALU_SRL: w_alu_res = r_b >> w_shamt;
            default: w_alu_res = r_a + w_alu_b;
        endcase
    end

    assign w_misalign = (w_alu_res[1:0] != 2'b00);

    always_comb begin
        w_state_next = r_state;
        w_retire     = 1'b0;
        w_pc_we      = 1'b0;
        w_pc_next    = r_npc;
        w_rf_we      = 1'b0;
        w_rf_waddr   = w_rd;
        w_rf_wdata   = r_alu_out;
        w_req        = 1'b0;
        w_we         = 1'b0;
        w_addr       = 32'd0;
        w_wdata      = 32'd0;
        case (r_state)
            S_FETCH: begin
                w_req  = 1'b1;
                w_addr = r_pc;
                if (i_mem_ready) w_state_next = S_DECODE;
            end
            S_DECODE: w_state_next = is_legal(w_op, w_fn) ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (w_is_r || (w_op == OP_ADDI)) begin
                    w_state_next = S_WB;
                end else if (w_is_mem) begin
                    w_state_next = (TRAP_ON_MISALIGN && w_misalign) ? S_TRAP : S_MEM;
                end else begin
                    w_state_next = S_FETCH;
                    w_retire     = 1'b1;
                    w_pc_we      = 1'b1;
                    if (w_is_br) w_pc_next = w_taken ? r_tgt : r_npc;
                    else         w_pc_next = {r_npc[31:28], r_ir[25:0], 2'b00};
                    if (w_op == OP_JAL) begin
                        w_rf_we    = 1'b1;
                        w_rf_waddr = 5'd31;
                        w_rf_wdata = r_npc;
                    end
                end
            end
            S_MEM: begin
                w_req   = 1'b1;
                w_we    = (w_op == OP_SW);
                w_addr  = {r_alu_out[31:2], 2'b00};
                w_wdata = w_we ? r_b : 32'd0;
                if (i_mem_ready) begin
                    if (w_we) begin
                        w_state_next = S_FETCH;
                        w_retire     = 1'b1;
                        w_pc_we      = 1'b1;
                    end else begin
                        w_state_next = S_WB;
                    end
                end
            end
            S_WB: begin
                w_rf_we      = 1'b1;
                w_rf_waddr   = w_is_r ? w_rd : w_rt;
                w_rf_wdata   = (w_op == OP_LW) ? r_mdr : r_alu_out;
                w_retire     = 1'b1;
                w_pc_we      = 1'b1;
                w_state_next = S_FETCH;
            end
            default: w_state_next = S_TRAP;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_npc     <= '0;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_tgt     <= '0;
            r_alu_out <= '0;
            r_mdr     <= '0;
            r_instret <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_FETCH && i_mem_ready) begin
                r_ir  <= i_mem_rdata;
                r_npc <= r_pc + 32'd4;
            end
            if (r_state == S_DECODE) begin
                r_a   <= w_rs_data;
                r_b   <= w_rt_data;
                r_tgt <= r_npc + {w_sext[29:0], 2'b00};
            end
            if (r_state == S_EXEC) r_alu_out <= w_alu_res;
            if (r_state == S_MEM && i_mem_ready) r_mdr <= i_mem_rdata;
            if (w_pc_we)  r_pc <= w_pc_next;
            if (w_retire) r_instret <= r_instret + 32'd1;
        end
    end

    // Request outputs drop the instant reset asserts, without waiting for a clock.
    assign o_mem_req     = w_req & i_rst_n;
    assign o_mem_we      = w_we & i_rst_n;
    assign o_mem_addr    = w_addr & {32{i_rst_n}};
    assign o_mem_wdata   = w_wdata & {32{i_rst_n}};
    assign o_pcout       = r_pc;
    assign o_instruction = r_ir;
    assign o_state       = r_state;
    assign o_halted      = (r_state == S_TRAP);
    assign o_instret     = r_instret;

endmodule
